// File: rtl/sr_pkg.sv
// Shared constants for the 8-bit shift-register link.
// Used by both the PISO transmitter and the SIPO receiver.
package sr_pkg;
  localparam int SR_WIDTH_DEFAULT = 8;
  localparam int SR_MSB_FIRST     = 1;
  localparam int SR_LSB_FIRST     = 0;
endpackage

// File: rtl/sr_sipo_eight_rx_if.sv
// Parallel word handshake between the receiver and its consumer.
// The master drives the word and its valid flag; the slave drives ready.
interface sr_sipo_eight_rx_if
  import sr_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH_DEFAULT
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter for the serial receiver.
// Flags the edge that samples the last bit of a word.
module sipo_shift_core
  import sr_pkg::*;
#(
  parameter int WIDTH     = SR_WIDTH_DEFAULT,
  parameter int MSB_FIRST = SR_MSB_FIRST
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sin,
  input  logic                     sin_valid,
  input  logic                     sync_clr,
  output logic                     done,
  output logic [WIDTH-1:0]         word,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sh;

  // Next shift value; on a completing edge this is the finished word.
  if (MSB_FIRST == SR_MSB_FIRST) begin : g_msb
    assign word = {sh[WIDTH-2:0], sin};
  end else begin : g_lsb
    assign word = {sin, sh[WIDTH-1:1]};
  end

  assign done = sin_valid && !sync_clr && (bit_cnt == LAST);

  // Shift in qualified bits; realign discards the partial word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (sync_clr) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (sin_valid) begin
      sh      <= word;
      bit_cnt <= done ? '0 : bit_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/sr_sipo_eight_rx.sv
// Serial-in parallel-out receiver with a one-word holding register.
// Words arriving while the consumer stalls are dropped and flagged.
module sr_sipo_eight_rx
  import sr_pkg::*;
#(
  parameter int WIDTH     = SR_WIDTH_DEFAULT,
  parameter int MSB_FIRST = SR_MSB_FIRST
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sin,
  input  logic                     sin_valid,
  input  logic                     sync_clr,
  input  logic                     ovr_clr,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  sr_sipo_eight_rx_if.master       pout
);
  logic             done;
  logic [WIDTH-1:0] word;
  logic             take;
  logic             ovr_ev;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sync_clr  (sync_clr),
    .done      (done),
    .word      (word),
    .bit_cnt   (bit_cnt)
  );

  // Load when the holding register is empty or drains this edge.
  assign take   = done && (!pout.out_valid || pout.out_ready);
  assign ovr_ev = done && pout.out_valid && !pout.out_ready;

  // Holding register and valid flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pout.out_data  <= '0;
      pout.out_valid <= 1'b0;
    end else if (take) begin
      pout.out_data  <= word;
      pout.out_valid <= 1'b1;
    end else if (pout.out_valid && pout.out_ready) begin
      pout.out_valid <= 1'b0;
    end
  end

  // Sticky overrun; a new drop beats a clear on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (ovr_ev) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sr_sipo_eight_rx.sv
// Directed bench for the SIPO receiver.
// Runs an MSB-first and an LSB-first instance on the same stream.
module tb_sr_sipo_eight_rx;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       sin;
  logic       sin_valid;
  logic       sync_clr;
  logic       ovr_clr;
  logic       out_ready;
  logic       ovr1, ovr0;
  logic [2:0] cnt1, cnt0;
  int         n_chk = 0;
  int         n_fail = 0;

  sr_sipo_eight_rx_if #(.WIDTH(8)) bus1 ();
  sr_sipo_eight_rx_if #(.WIDTH(8)) bus0 ();

  assign bus1.out_ready = out_ready;
  assign bus0.out_ready = out_ready;

  always #5 clk = ~clk;

  sr_sipo_eight_rx #(.WIDTH(8), .MSB_FIRST(1)) dut1 (
    .clk       (clk),
    .reset     (rst_n),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sync_clr  (sync_clr),
    .ovr_clr   (ovr_clr),
    .overrun   (ovr1),
    .bit_cnt   (cnt1),
    .pout      (bus1.master)
  );

  sr_sipo_eight_rx #(.WIDTH(8), .MSB_FIRST(0)) dut0 (
    .clk       (clk),
    .reset     (rst_n),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sync_clr  (sync_clr),
    .ovr_clr   (ovr_clr),
    .overrun   (ovr0),
    .bit_cnt   (cnt0),
    .pout      (bus0.master)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    sin       = b;
    sin_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sin_valid = 1'b0;
      sync_clr  = 1'b0;
      ovr_clr   = 1'b0;
    end
  endtask

  // Stream sent first-bit-first as w[7], w[6], ... w[0].
  task automatic send_word(input logic [7:0] w, input int gap);
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i]);
      if (gap > 0) begin
        idle(gap);
        chk("gap_cnt", 32'(cnt1), 32'((8 - i) % 8));
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    sin       = 1'b0;
    sin_valid = 1'b0;
    sync_clr  = 1'b0;
    ovr_clr   = 1'b0;
    out_ready = 1'b1;
    #3;
    chk("rst_data",  32'(bus1.out_data), 32'h0);
    chk("rst_valid", 32'(bus1.out_valid), 32'h0);
    chk("rst_ovr",   32'(ovr1), 32'h0);
    chk("rst_cnt",   32'(cnt1), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame capture
    send_word(8'hA5, 0);
    idle(1);
    chk("a5_valid", 32'(bus1.out_valid), 32'h1);
    chk("a5_data1", 32'(bus1.out_data), 32'hA5);
    chk("a5_data0", 32'(bus0.out_data), 32'hA5);
    idle(1);
    chk("a5_drop", 32'(bus1.out_valid), 32'h0);

    // Bit order
    send_word(8'hF0, 0);
    idle(1);
    chk("ord_msb", 32'(bus1.out_data), 32'hF0);
    chk("ord_lsb", 32'(bus0.out_data), 32'h0F);

    // Gapped input
    send_word(8'h3C, 3);
    chk("gap_data", 32'(bus1.out_data), 32'h3C);
    chk("gap_end",  32'(cnt1), 32'h0);

    // Overrun
    out_ready = 1'b0;
    send_word(8'h22, 0);
    send_word(8'h1E, 0);
    idle(1);
    chk("ovr_data",  32'(bus1.out_data), 32'h22);
    chk("ovr_valid", 32'(bus1.out_valid), 32'h1);
    chk("ovr_flag",  32'(ovr1), 32'h1);
    @(negedge clk);
    ovr_clr = 1'b1;
    idle(1);
    chk("ovr_clr", 32'(ovr1), 32'h0);
    chk("ovr_hold", 32'(bus1.out_data), 32'h22);
    out_ready = 1'b1;
    idle(1);
    chk("ovr_drain", 32'(bus1.out_valid), 32'h0);

    // Simultaneous consume and complete
    out_ready = 1'b0;
    send_word(8'hA1, 0);
    idle(1);
    chk("a1_data", 32'(bus1.out_data), 32'hA1);
    for (int i = 7; i >= 1; i--) send_bit(8'h6F >> i);
    @(negedge clk);
    sin       = 1'b1;
    sin_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    sin_valid = 1'b0;
    out_ready = 1'b0;
    chk("sim_data",  32'(bus1.out_data), 32'h6F);
    chk("sim_valid", 32'(bus1.out_valid), 32'h1);
    chk("sim_ovr",   32'(ovr1), 32'h0);
    out_ready = 1'b1;
    idle(1);
    chk("sim_drain", 32'(bus1.out_valid), 32'h0);

    // Reset mid-word, with a held word pending
    out_ready = 1'b0;
    send_word(8'h55, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    idle(1);
    chk("pre_cnt",   32'(cnt1), 32'h4);
    chk("pre_valid", 32'(bus1.out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_data",  32'(bus1.out_data), 32'h0);
    chk("ar_valid", 32'(bus1.out_valid), 32'h0);
    chk("ar_cnt",   32'(cnt1), 32'h0);
    chk("ar_ovr",   32'(ovr1), 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send_word(8'h18, 0);
    idle(1);
    chk("rr_data",  32'(bus1.out_data), 32'h18);
    chk("rr_valid", 32'(bus1.out_valid), 32'h1);

    // Realign
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    @(negedge clk);
    sin       = 1'b1;
    sin_valid = 1'b1;
    sync_clr  = 1'b1;
    idle(1);
    chk("sc_cnt",  32'(cnt1), 32'h0);
    chk("sc_hold", 32'(bus1.out_data), 32'h18);
    send_word(8'h03, 0);
    idle(1);
    chk("sc_data1", 32'(bus1.out_data), 32'h03);
    chk("sc_data0", 32'(bus0.out_data), 32'hC0);
    chk("sc_valid", 32'(bus1.out_valid), 32'h1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
